// File: rtl/adder_stream_ctrl.sv
// Operand collector and result streamer for the external multi-precision adder.
// Loads A then B word by word, holds them for the settle window, then streams the sum out.
module adder_stream_ctrl #(
    parameter int ADDER_WIDTH = 128,
    parameter int WORD_WIDTH  = 32,
    parameter int ADD_CYCLES  = 2
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic [WORD_WIDTH-1:0]  iData,
    input  logic                   iValid,
    input  logic                   iCin,
    output logic                   oReady,
    output logic [WORD_WIDTH-1:0]  oData,
    output logic                   oValid,
    output logic                   oLast,
    output logic                   oCout,
    input  logic                   iReady,
    output logic [ADDER_WIDTH-1:0] oAdderA,
    output logic [ADDER_WIDTH-1:0] oAdderB,
    output logic                   oAdderC,
    input  logic [ADDER_WIDTH-1:0] iAdderSum,
    input  logic                   iAdderC
);

    localparam int N  = ADDER_WIDTH / WORD_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_WORD   = CW'(N - 1);
    localparam logic [3:0]    SETTLE_LAST = 4'(ADD_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        ADD,
        SEND
    } state_t;

    state_t                 state, state_nxt;
    logic [CW-1:0]          word_cnt, word_cnt_nxt;
    logic [3:0]             settle_cnt, settle_cnt_nxt;
    logic [ADDER_WIDTH-1:0] a_reg, b_reg, result_reg;
    logic                   cin_reg, cout_reg;

    logic in_fire, out_fire, last_word, settle_done;

    assign oReady      = (state == LOAD_A) || (state == LOAD_B);
    assign oValid      = (state == SEND);
    assign in_fire     = iValid && oReady;
    assign out_fire    = oValid && iReady;
    assign last_word   = (word_cnt == LAST_WORD);
    assign settle_done = (state == ADD) && (settle_cnt == SETTLE_LAST);

    assign oData   = result_reg[word_cnt*WORD_WIDTH +: WORD_WIDTH];
    assign oLast   = oValid && last_word;
    assign oCout   = cout_reg;
    assign oAdderA = a_reg;
    assign oAdderB = b_reg;
    assign oAdderC = cin_reg;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state      <= LOAD_A;
            word_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            word_cnt   <= word_cnt_nxt;
            settle_cnt <= settle_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        word_cnt_nxt   = word_cnt;
        settle_cnt_nxt = settle_cnt;
        case (state)
            LOAD_A: begin
                if (in_fire) begin
                    if (last_word) begin
                        state_nxt    = LOAD_B;
                        word_cnt_nxt = '0;
                    end else begin
                        word_cnt_nxt = word_cnt + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (in_fire) begin
                    if (last_word) begin
                        state_nxt      = ADD;
                        word_cnt_nxt   = '0;
                        settle_cnt_nxt = '0;
                    end else begin
                        word_cnt_nxt = word_cnt + 1'b1;
                    end
                end
            end
            ADD: begin
                if (settle_done) begin
                    state_nxt      = SEND;
                    word_cnt_nxt   = '0;
                    settle_cnt_nxt = '0;
                end else begin
                    settle_cnt_nxt = settle_cnt + 1'b1;
                end
            end
            SEND: begin
                if (out_fire) begin
                    if (last_word) begin
                        state_nxt    = LOAD_A;
                        word_cnt_nxt = '0;
                    end else begin
                        word_cnt_nxt = word_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt      = LOAD_A;
                word_cnt_nxt   = '0;
                settle_cnt_nxt = '0;
            end
        endcase
    end

    // Operands only move while loading, so the adder inputs are frozen for the whole ADD window
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            cin_reg    <= 1'b0;
            cout_reg   <= 1'b0;
        end else begin
            if (in_fire && (state == LOAD_A)) begin
                a_reg[word_cnt*WORD_WIDTH +: WORD_WIDTH] <= iData;
                if (word_cnt == '0) begin
                    cin_reg <= iCin;
                end
            end
            if (in_fire && (state == LOAD_B)) begin
                b_reg[word_cnt*WORD_WIDTH +: WORD_WIDTH] <= iData;
            end
            if (settle_done) begin
                result_reg <= iAdderSum;
                cout_reg   <= iAdderC;
            end
        end
    end

endmodule

// File: tb/tb_adder_stream_ctrl.sv
// Testbench for adder_stream_ctrl: drives operand streams, models the external adder,
// and checks result streams against sums computed directly from the sent operands.
module tb_adder_stream_ctrl;

    localparam int AW = 128;
    localparam int WW = 32;
    localparam int AC = 2;

    logic          iClk, iRst;
    logic [WW-1:0] iData;
    logic          iValid, iCin, iReady;
    logic          oReady, oValid, oLast, oCout, oAdderC;
    logic [WW-1:0] oData;
    logic [AW-1:0] oAdderA, oAdderB, adder_sum;
    logic          adder_c;
    logic [AW:0]   cin_ext;

    int checks = 0;
    int errors = 0;

    adder_stream_ctrl #(.ADDER_WIDTH(AW), .WORD_WIDTH(WW), .ADD_CYCLES(AC)) dut (
        .iClk(iClk), .iRst(iRst), .iData(iData), .iValid(iValid), .iCin(iCin),
        .oReady(oReady), .oData(oData), .oValid(oValid), .oLast(oLast), .oCout(oCout),
        .iReady(iReady), .oAdderA(oAdderA), .oAdderB(oAdderB), .oAdderC(oAdderC),
        .iAdderSum(adder_sum), .iAdderC(adder_c)
    );

    // External adder
    assign cin_ext = {{AW{1'b0}}, oAdderC};
    assign {adder_c, adder_sum} = {1'b0, oAdderA} + {1'b0, oAdderB} + cin_ext;

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Runs one transaction from a negedge; returns at the negedge after the stop-th transfer.
    task automatic do_txn(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic cin,
                          input bit in_stall, input bit out_stall, input int stop,
                          output logic [AW-1:0] res, output logic cout, output logic [3:0] last_mask,
                          output int add_cnt, output int add_bad, output int ready_bad,
                          output int hold_err, output logic ready_after, output bit tmo);
        int k, n, p, guard;
        bit tog, acc, take, r, have_prev, prev_taken;
        logic [WW-1:0] prev_data;
        logic prev_last, prev_cout;
        int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        k = 0; n = 0; p = 0; guard = 0; tog = 1'b0; have_prev = 1'b0; prev_taken = 1'b0;
        prev_data = '0; prev_last = 1'b0; prev_cout = 1'b0;
        res = '0; cout = 1'b0; last_mask = '0;
        add_cnt = 0; add_bad = 0; ready_bad = 0; hold_err = 0; tmo = 1'b0;
        while (k < 8 && guard < 200) begin
            tog = in_stall ? !tog : 1'b1;
            iValid = tog;
            iData  = tog ? ((k < 4) ? a[k*WW +: WW] : b[(k-4)*WW +: WW]) : $urandom;
            iCin   = (tog && k == 0) ? cin : 1'($urandom);
            iReady = 1'($urandom);
            acc = tog && oReady;
            @(negedge iClk); guard++;
            if (acc) k++;
        end
        while (!oValid && guard < 200) begin
            add_cnt++;
            if (oReady) ready_bad++;
            if (oAdderA !== a || oAdderB !== b || oAdderC !== cin) add_bad++;
            iValid = 1'($urandom); iData = $urandom; iReady = 1'($urandom);
            @(negedge iClk); guard++;
        end
        while (n < stop && guard < 200) begin
            if (oReady || !oValid) ready_bad++;
            if (have_prev && !prev_taken &&
                (oData !== prev_data || oLast !== prev_last || oCout !== prev_cout)) hold_err++;
            r = out_stall ? pat[p % 7] != 0 : 1'b1;
            p++;
            iReady = r;
            take = r && oValid;
            if (take) begin
                res[n*WW +: WW] = oData;
                if (oLast) last_mask[n] = 1'b1;
                cout = oCout;
                n++;
            end
            iValid = (take && n == 4) ? 1'b0 : 1'($urandom);
            iData  = $urandom;
            prev_data = oData; prev_last = oLast; prev_cout = oCout;
            prev_taken = take; have_prev = 1'b1;
            @(negedge iClk); guard++;
        end
        iValid = 1'b0; iReady = 1'b0;
        ready_after = oReady;
        tmo = (n < stop);
    endtask

    task automatic test_reset();
        iRst = 1'b1; iValid = 1'b0; iReady = 1'b0; iData = '0; iCin = 1'b0;
        repeat (2) @(negedge iClk);
        checks++;
        if (oReady !== 1'b1 || oValid !== 1'b0 || oLast !== 1'b0 || oCout !== 1'b0 ||
            oData !== '0 || oAdderA !== '0 || oAdderB !== '0 || oAdderC !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b last=%b cout=%b data=%h c=%b", oReady, oValid, oLast, oCout, oData, oAdderC);
        end
        iRst = 1'b0;
        @(negedge iClk);
    endtask

    task automatic test_vector(input string name, input logic [AW-1:0] a, input logic [AW-1:0] b,
                               input logic cin, input logic [AW-1:0] exp_r, input logic exp_c);
        logic [AW-1:0] res; logic cout, ra; logic [3:0] lm; int ac, ab, rb, he; bit tmo;
        do_txn(a, b, cin, 1'b0, 1'b0, 4, res, cout, lm, ac, ab, rb, he, ra, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL %s timeout got no result want 4 words", name); end
        checks++;
        if (res !== exp_r || cout !== exp_c) begin
            errors++; $display("FAIL %s result got %h/%b want %h/%b", name, res, cout, exp_r, exp_c);
        end
        checks++;
        if (lm !== 4'b1000) begin errors++; $display("FAIL %s olast got %b want 1000", name, lm); end
        checks++;
        if (ab != 0) begin errors++; $display("FAIL %s adder_inputs got %0d bad cycles want 0", name, ab); end
    endtask

    task automatic test_latency();
        logic [AW-1:0] a, b, res; logic [AW:0] exp; logic cin, cout, ra; logic [3:0] lm;
        int ac, ab, rb, he; bit tmo;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        cin = 1'($urandom);
        exp = {1'b0, a} + {1'b0, b} + {{AW{1'b0}}, cin};
        do_txn(a, b, cin, 1'b0, 1'b0, 4, res, cout, lm, ac, ab, rb, he, ra, tmo);
        checks++;
        if (ac != AC) begin errors++; $display("FAIL latency_add_cycles got %0d want %0d", ac, AC); end
        checks++;
        if (rb != 0) begin errors++; $display("FAIL latency_oready_low got %0d bad cycles want 0", rb); end
        checks++;
        if (ra !== 1'b1) begin errors++; $display("FAIL latency_ready_after got %b want 1", ra); end
        checks++;
        if ({cout, res} !== exp || tmo) begin
            errors++; $display("FAIL latency_result got %h want %h", {cout, res}, exp);
        end
    endtask

    task automatic test_stalls();
        logic [AW-1:0] a, b, res; logic [AW:0] exp; logic cout, ra; logic [3:0] lm;
        int ac, ab, rb, he; bit tmo;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        exp = {1'b0, a} + {1'b0, b} + {{AW{1'b0}}, 1'b1};
        do_txn(a, b, 1'b1, 1'b1, 1'b1, 4, res, cout, lm, ac, ab, rb, he, ra, tmo);
        checks++;
        if (ab != 0) begin errors++; $display("FAIL stall_operands got %0d bad cycles want 0", ab); end
        checks++;
        if (he != 0) begin errors++; $display("FAIL stall_hold got %0d changes want 0", he); end
        checks++;
        if ({cout, res} !== exp || tmo) begin
            errors++; $display("FAIL stall_result got %h want %h", {cout, res}, exp);
        end
        checks++;
        if (ra !== 1'b1 || lm !== 4'b1000) begin
            errors++; $display("FAIL stall_ready_after got rdy=%b last=%b want 1/1000", ra, lm);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a, b, res; logic [AW:0] exp; logic cin, cout, ra; logic [3:0] lm;
        int ac, ab, rb, he; bit tmo;
        for (int t = 0; t < 6; t++) begin
            a = (t == 0) ? {AW{1'b1}} : {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            cin = 1'($urandom);
            exp = {1'b0, a} + {1'b0, b} + {{AW{1'b0}}, cin};
            do_txn(a, b, cin, t[0], t[1], 4, res, cout, lm, ac, ab, rb, he, ra, tmo);
            checks++;
            if ({cout, res} !== exp || lm !== 4'b1000 || he != 0 || ab != 0 || rb != 0 || tmo) begin
                errors++;
                $display("FAIL random_%0d got %h last=%b hold=%0d opnd=%0d rdy=%0d want %h last=1000",
                         t, {cout, res}, lm, he, ab, rb, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] res; logic cout, ra; logic [3:0] lm; int ac, ab, rb, he; bit tmo;
        for (int k = 0; k < 5; k++) begin
            iValid = 1'b1; iData = $urandom | 32'h1; iCin = 1'b1;
            @(negedge iClk);
        end
        iValid = 1'b0;
        #2 iRst = 1'b1;
        #1;
        checks++;
        if (oReady !== 1'b1 || oValid !== 1'b0 || oAdderA !== '0 || oAdderB !== '0 || oAdderC !== 1'b0) begin
            errors++; $display("FAIL reset_mid_load got rdy=%b vld=%b a=%h c=%b want 1/0/0/0", oReady, oValid, oAdderA, oAdderC);
        end
        @(negedge iClk); iRst = 1'b0;
        @(negedge iClk);
        do_txn({AW{1'b1}}, {{(AW-WW){1'b0}}, 32'h0000_0002}, 1'b0, 1'b0, 1'b0, 1,
               res, cout, lm, ac, ab, rb, he, ra, tmo);
        checks++;
        if (tmo || oValid !== 1'b1 || oData !== '0 && 1'b0) begin
            errors++; $display("FAIL reset_mid_send_setup got vld=%b want 1", oValid);
        end
        #2 iRst = 1'b1;
        #1;
        checks++;
        if (oValid !== 1'b0 || oReady !== 1'b1 || oLast !== 1'b0 || oCout !== 1'b0 || oData !== '0 ||
            oAdderA !== '0 || oAdderB !== '0 || oAdderC !== 1'b0) begin
            errors++; $display("FAIL reset_mid_send got vld=%b rdy=%b last=%b cout=%b data=%h want 0/1/0/0/0",
                               oValid, oReady, oLast, oCout, oData);
        end
        @(negedge iClk); iRst = 1'b0;
        @(negedge iClk);
        test_vector("after_reset", 128'd5, 128'd7, 1'b0, 128'h0000000C, 1'b0);
    endtask

    initial begin
        iRst = 1'b1; iValid = 1'b0; iReady = 1'b0; iData = '0; iCin = 1'b0;
        test_reset();
        test_vector("carry_full", {AW{1'b1}}, 128'd1, 1'b0, '0, 1'b1);
        test_vector("carry_in", '0, '0, 1'b1, 128'd1, 1'b0);
        test_vector("cross_word", 128'h12345678_00000000_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0,
                    128'h12345678_00000001_00000000_00000000, 1'b0);
        test_latency();
        test_stalls();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
